// File: rtl/traffic_phase_timer_if.sv
// Lamp/countdown bundle of the traffic phase timer: pedestrian request in, lamps, BCD digits
// and the one-second tick out.
interface traffic_phase_timer_if;
  logic       ped_req;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [3:0] digit_tens;
  logic [3:0] digit_ones;
  logic       tick;

  modport master (
    input  ped_req,
    output ns_light, ew_light, digit_tens, digit_ones, tick
  );

  modport slave (
    output ped_req,
    input  ns_light, ew_light, digit_tens, digit_ones, tick
  );
endinterface

// File: rtl/traffic_phase_timer.sv
// Traffic light sequencer: tick prescaler, six-phase light FSM and a BCD countdown of the
// seconds left in the phase. rst is expected to be released synchronously to clk.
module traffic_phase_timer #(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned GREEN_TIME  = 30,
  parameter int unsigned YELLOW_TIME = 5,
  parameter int unsigned RED_CLEAR   = 2,
  parameter int unsigned PED_GREEN   = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  traffic_phase_timer_if.master  bus_io
);

  localparam int unsigned PrescW = $clog2(TICK_DIV);
  localparam logic [PrescW-1:0] PrescLast = PrescW'(TICK_DIV - 1);

  // Durations split into BCD digits at elaboration; nothing divides at runtime.
  localparam logic [7:0] GreenBcd  = {4'(GREEN_TIME / 10), 4'(GREEN_TIME % 10)};
  localparam logic [7:0] YellowBcd = {4'(YELLOW_TIME / 10), 4'(YELLOW_TIME % 10)};
  localparam logic [7:0] RedBcd    = {4'(RED_CLEAR / 10), 4'(RED_CLEAR % 10)};
  localparam logic [7:0] PedBcd    = {4'(PED_GREEN / 10), 4'(PED_GREEN % 10)};

  typedef enum logic [2:0] {
    StNsGreen, StNsYellow, StRedA, StEwGreen, StEwYellow, StRedB
  } state_e;

  logic [PrescW-1:0] presc_q, presc_d;
  logic              tick;
  state_e            state_q, state_d;
  logic [3:0]        tens_q, tens_d, ones_q, ones_d;
  logic              ped_pend_q, ped_pend_d;
  logic [2:0]        ns_q, ns_d, ew_q, ew_d;
  logic              is_green, ped_any;

  assign tick    = (presc_q == PrescLast);
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  function automatic state_e next_state(state_e s);
    unique case (s)
      StNsGreen:  return StNsYellow;
      StNsYellow: return StRedA;
      StRedA:     return StEwGreen;
      StEwGreen:  return StEwYellow;
      StEwYellow: return StRedB;
      default:    return StNsGreen;
    endcase
  endfunction

  function automatic logic [7:0] duration(state_e s);
    unique case (s)
      StNsGreen, StEwGreen:   return GreenBcd;
      StNsYellow, StEwYellow: return YellowBcd;
      default:                return RedBcd;
    endcase
  endfunction

  assign is_green = (state_q == StNsGreen) || (state_q == StEwGreen);
  assign ped_any  = ped_pend_q | bus_io.ped_req;

  always_comb begin
    state_d    = state_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    ped_pend_d = ped_pend_q;
    if (tick) begin
      if ({tens_q, ones_q} == 8'h01) begin
        state_d          = next_state(state_q);
        {tens_d, ones_d} = duration(state_d);
        if ((state_d == StNsYellow) || (state_d == StEwYellow)) begin
          ped_pend_d = 1'b0;
        end
      end else if (is_green && ped_any && ({tens_q, ones_q} > PedBcd)) begin
        {tens_d, ones_d} = PedBcd;
        ped_pend_d       = 1'b0;
      end else if (ones_q == 4'd0) begin
        ones_d = 4'd9;
        tens_d = tens_q - 4'd1;
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
    // A new request in the same cycle outranks any clear above.
    if (bus_io.ped_req) begin
      ped_pend_d = 1'b1;
    end
  end

  always_comb begin
    ns_d = 3'b100;
    ew_d = 3'b100;
    unique case (state_d)
      StNsGreen:  ns_d = 3'b001;
      StNsYellow: ns_d = 3'b010;
      StEwGreen:  ew_d = 3'b001;
      StEwYellow: ew_d = 3'b010;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q          <= '0;
      state_q          <= StNsGreen;
      {tens_q, ones_q} <= GreenBcd;
      ped_pend_q       <= 1'b0;
      ns_q             <= 3'b001;
      ew_q             <= 3'b100;
    end else begin
      presc_q    <= presc_d;
      state_q    <= state_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      ped_pend_q <= ped_pend_d;
      ns_q       <= ns_d;
      ew_q       <= ew_d;
    end
  end

  assign bus_io.ns_light   = ns_q;
  assign bus_io.ew_light   = ew_q;
  assign bus_io.digit_tens = tens_q;
  assign bus_io.digit_ones = ones_q;
  assign bus_io.tick       = tick;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Bench for traffic_phase_timer: binary-countdown reference model feeds a scoreboard queue,
// plus directed checks for reset, BCD borrow, pedestrian cut, late request and mid-phase reset.
module tb_traffic_phase_timer;

  localparam int unsigned TD  = 4;
  localparam int unsigned GT  = 12;
  localparam int unsigned YT  = 3;
  localparam int unsigned RC  = 1;
  localparam int unsigned PG  = 2;

  typedef struct packed {
    logic [2:0] st;   // 0 NsG, 1 NsY, 2 RedA, 3 EwG, 4 EwY, 5 RedB
    logic [7:0] rem;  // remaining ticks, binary
    logic       ped;
  } mdl_t;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       ped;
  } exp_t;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  mdl_t m;
  int   m_presc;
  exp_t exp_q[$];

  traffic_phase_timer_if tpt_if ();

  traffic_phase_timer #(
    .TICK_DIV   (TD),
    .GREEN_TIME (GT),
    .YELLOW_TIME(YT),
    .RED_CLEAR  (RC),
    .PED_GREEN  (PG)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(tpt_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] dur(input logic [2:0] st);
    case (st)
      3'd0, 3'd3: return 8'(GT);
      3'd1, 3'd4: return 8'(YT);
      default:    return 8'(RC);
    endcase
  endfunction

  function automatic mdl_t mdl_step(input mdl_t mi, input logic req);
    mdl_t r;
    r = mi;
    if (mi.rem == 8'd1) begin
      r.st  = (mi.st == 3'd5) ? 3'd0 : mi.st + 3'd1;
      r.rem = dur(r.st);
      if (r.st == 3'd1 || r.st == 3'd4) r.ped = 1'b0;
    end else if ((mi.st == 3'd0 || mi.st == 3'd3) && (mi.ped || req) && mi.rem > 8'(PG)) begin
      r.rem = 8'(PG);
      r.ped = 1'b0;
    end else begin
      r.rem = mi.rem - 8'd1;
    end
    if (req) r.ped = 1'b1;
    return r;
  endfunction

  function automatic exp_t mdl_expect(input mdl_t mi);
    exp_t e;
    e.ns   = (mi.st == 3'd0) ? 3'b001 : (mi.st == 3'd1) ? 3'b010 : 3'b100;
    e.ew   = (mi.st == 3'd3) ? 3'b001 : (mi.st == 3'd4) ? 3'b010 : 3'b100;
    e.tens = 4'(int'(mi.rem) / 10);
    e.ones = 4'(int'(mi.rem) % 10);
    e.ped  = mi.ped;
    return e;
  endfunction

  // Reference model: expectations queued on each modelled tick.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_presc <= 0;
      m       <= '{st: 3'd0, rem: 8'(GT), ped: 1'b0};
      exp_q.delete();
    end else begin
      m_presc <= (m_presc == int'(TD) - 1) ? 0 : m_presc + 1;
      if (m_presc == int'(TD) - 1) begin
        m <= mdl_step(m, tpt_if.ped_req);
        exp_q.push_back(mdl_expect(mdl_step(m, tpt_if.ped_req)));
      end else if (tpt_if.ped_req) begin
        m.ped <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check_eq("tick", 8'(tpt_if.tick), 8'(m_presc == int'(TD) - 1));
      check_eq("ns_onehot", 8'($onehot(tpt_if.ns_light)), 8'd1);
      check_eq("ew_onehot", 8'($onehot(tpt_if.ew_light)), 8'd1);
      check_eq("lamp_excl", 8'(tpt_if.ns_light[2] == 1'b0 && tpt_if.ew_light[2] == 1'b0),
               8'd0);
      if (exp_q.size() != 0) begin
        check_eq("sb_ns", 8'(tpt_if.ns_light), 8'(exp_q[0].ns));
        check_eq("sb_ew", 8'(tpt_if.ew_light), 8'(exp_q[0].ew));
        check_eq("sb_tens", 8'(tpt_if.digit_tens), 8'(exp_q[0].tens));
        check_eq("sb_ones", 8'(tpt_if.digit_ones), 8'(exp_q[0].ones));
        check_eq("sb_ped", 8'(dut.ped_pend_q), 8'(exp_q[0].ped));
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n * int'(TD)) @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic [2:0] ns, input logic [2:0] ew,
                           input logic [3:0] tens, input logic [3:0] ones);
    check_eq({tag, "_ns"}, 8'(tpt_if.ns_light), 8'(ns));
    check_eq({tag, "_ew"}, 8'(tpt_if.ew_light), 8'(ew));
    check_eq({tag, "_tens"}, 8'(tpt_if.digit_tens), 8'(tens));
    check_eq({tag, "_ones"}, 8'(tpt_if.digit_ones), 8'(ones));
  endtask

  task automatic release_and_check_first_tick(input string tag);
    rst = 1'b0;
    check_eq({tag, "_tick_c0"}, 8'(tpt_if.tick), 8'd0);
    repeat (2) @(negedge clk);
    check_eq({tag, "_tick_c2"}, 8'(tpt_if.tick), 8'd0);
    @(negedge clk);
    check_eq({tag, "_tick_c3"}, 8'(tpt_if.tick), 8'd1);
    @(negedge clk);
    check_out({tag, "_t1"}, 3'b001, 3'b100, 4'd1, 4'd1);
  endtask

  initial begin
    rst            = 1'b1;
    tpt_if.ped_req = 1'b0;
    repeat (3) @(negedge clk);
    check_out("rst", 3'b001, 3'b100, 4'd1, 4'd2);
    check_eq("rst_tick", 8'(tpt_if.tick), 8'd0);
    check_eq("rst_ped", 8'(dut.ped_pend_q), 8'd0);
    release_and_check_first_tick("rel");

    // BCD borrow and first phase change
    wait_ticks(1);
    check_out("t2", 3'b001, 3'b100, 4'd1, 4'd0);
    wait_ticks(1);
    check_out("borrow", 3'b001, 3'b100, 4'd0, 4'd9);
    wait_ticks(9);
    check_out("t12_nsy", 3'b010, 3'b100, 4'd0, 4'd3);
    wait_ticks(20);
    check_out("t32_wrap", 3'b001, 3'b100, 4'd1, 4'd2);

    // Pedestrian cut at 08
    wait_ticks(4);
    check_out("pre_cut", 3'b001, 3'b100, 4'd0, 4'd8);
    tpt_if.ped_req = 1'b1;
    @(negedge clk);
    tpt_if.ped_req = 1'b0;
    check_eq("ped_latched", 8'(dut.ped_pend_q), 8'd1);
    repeat (int'(TD) - 1) @(negedge clk);
    check_out("cut", 3'b001, 3'b100, 4'd0, 4'd2);
    check_eq("cut_ped_clr", 8'(dut.ped_pend_q), 8'd0);
    wait_ticks(1);
    check_out("cut_01", 3'b001, 3'b100, 4'd0, 4'd1);
    wait_ticks(1);
    check_out("cut_nsy", 3'b010, 3'b100, 4'd0, 4'd3);

    // Late request at 02 in EW green: no cut
    wait_ticks(14);
    check_out("late_pre", 3'b100, 3'b001, 4'd0, 4'd2);
    tpt_if.ped_req = 1'b1;
    @(negedge clk);
    tpt_if.ped_req = 1'b0;
    repeat (int'(TD) - 1) @(negedge clk);
    check_out("late_01", 3'b100, 3'b001, 4'd0, 4'd1);
    check_eq("late_ped_held", 8'(dut.ped_pend_q), 8'd1);
    wait_ticks(1);
    check_out("late_ewy", 3'b100, 3'b010, 4'd0, 4'd3);
    check_eq("late_ped_clr", 8'(dut.ped_pend_q), 8'd0);
    wait_ticks(4);
    check_out("full_ng12", 3'b001, 3'b100, 4'd1, 4'd2);
    wait_ticks(11);
    check_out("full_ng01", 3'b001, 3'b100, 4'd0, 4'd1);
    wait_ticks(1);
    check_out("full_nsy", 3'b010, 3'b100, 4'd0, 4'd3);

    // Mid-phase asynchronous reset in EW yellow
    wait_ticks(16);
    check_out("ewy_pre", 3'b100, 3'b010, 4'd0, 4'd3);
    wait_ticks(1);
    repeat (2) @(negedge clk);
    check_out("ewy_mid", 3'b100, 3'b010, 4'd0, 4'd2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_out("async_rst", 3'b001, 3'b100, 4'd1, 4'd2);
    check_eq("async_rst_ped", 8'(dut.ped_pend_q), 8'd0);
    check_eq("async_rst_tick", 8'(tpt_if.tick), 8'd0);
    @(negedge clk);
    release_and_check_first_tick("rel2");
    wait_ticks(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_phase_timer.md
# traffic_phase_timer

Sequencing core of the traffic light controller: divides the system clock into a one-second tick, steps a two-road (north-south / east-west) light-phase state machine, and counts down the seconds left in the current phase. It drives the lamp outputs and presents the remaining time as two BCD digits, tens and ones. Each digit feeds its own downstream 4-bit-to-7-segment decoder.

## Interface
- TICK_DIV, 50_000_000: clock cycles per tick; ≥2
- GREEN_TIME, 30: green phase length in ticks; 1..99
- YELLOW_TIME, 5: yellow phase length in ticks; 1..99
- RED_CLEAR, 2: all-red clearance length in ticks; 1..99
- PED_GREEN, 5: remaining-time cap applied to a green phase on pedestrian request; 1..GREEN_TIME
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- ped_req  in  1  pedestrian request, level or pulse, sampled every cycle
- ns_light  out  3  north-south lamps {red,yellow,green}, one-hot
- ew_light  out  3  east-west lamps {red,yellow,green}, one-hot
- digit_tens  out  4  BCD tens of remaining ticks, 0..9
- digit_ones  out  4  BCD ones of remaining ticks, 0..9
- tick  out  1  one-cycle pulse every TICK_DIV cycles

## Operation
- Prescaler: counter 0..TICK_DIV-1, wraps to 0. tick=1 exactly in the cycle where counter==TICK_DIV-1.
- States in fixed cycle order: NS_GREEN → NS_YELLOW → RED_A → EW_GREEN → EW_YELLOW → RED_B → NS_GREEN.
- Lamps are a pure Moore function of state:
  - NS_GREEN: ns=001, ew=100
  - NS_YELLOW: ns=010, ew=100
  - RED_A, RED_B: ns=100, ew=100
  - EW_GREEN: ns=100, ew=001
  - EW_YELLOW: ns=100, ew=010
  - Never two greens; never green/yellow on both roads.
- Countdown held as two BCD digits, not binary. Load values are per-state constants split into tens/ones at elaboration. No runtime division.
- On each tick:
  - If count==01, advance to next state and load that state's duration.
  - Otherwise decrement in BCD: ones==0 → ones=9, tens-=1; else ones-=1.
- Displayed sequence per phase is duration, duration-1, …, 1. 00 is never displayed.
- Pedestrian latch `ped_pend` is set in any cycle with ped_req=1.
  - On a tick in NS_GREEN or EW_GREEN with ped_pend=1 and count>PED_GREEN: load count=PED_GREEN instead of decrementing, and clear ped_pend.
  - If count≤PED_GREEN in that case, decrement normally and leave ped_pend set.
  - ped_pend is cleared on entry to either yellow state, because the request is served by the crossing change.
  - Set wins over clear in the same cycle.
- Outside green states, ped_pend only accumulates.

## Timing
- Reset (async assert, sync deassert into the clk domain):
  - prescaler=0, tick=0
  - state=NS_GREEN, count=GREEN_TIME in BCD, ped_pend=0
  - ns_light=001, ew_light=100
- First tick is high in cycle TICK_DIV-1 after reset release (cycles counted from 0). Ticks then repeat every TICK_DIV cycles.
- State, count, lamps and digits update on the rising edge that ends the tick cycle. They are stable for the following TICK_DIV cycles. Latency from tick to output change is 1 clock.
- All outputs are registered or a decode of registered state only. No combinational path from ped_req to any output.
- ped_req high in the same cycle as a qualifying tick takes effect on that tick.
- Reset asserted mid-phase returns immediately to the reset values above. No partial phase is resumed.
- Full cycle = 2·(GREEN_TIME+YELLOW_TIME+RED_CLEAR) ticks. This is 74 ticks with default parameters.

## Test plan
Bench parameters for all scenarios: TICK_DIV=4, GREEN_TIME=12, YELLOW_TIME=3, RED_CLEAR=1, PED_GREEN=2.
- Reset: hold rst, then release. Required: ns=001, ew=100, digits 1/2, tick=0. First tick at cycle 3. After the edge following it, digits read 1/1.
- BCD borrow: after 2 ticks from reset, digits=1/0. The next tick gives 0/9. At tick 12, the state is NS_YELLOW, ns=010, digits 0/3.
- Full rotation, no ped_req:
  - Lamp/digit sequence is NS_GREEN 12..1, NS_YELLOW 3..1, RED_A 1, EW_GREEN 12..1, EW_YELLOW 3..1, RED_B 1.
  - Back in NS_GREEN with digits 1/2 after 32 ticks, which is 128 clocks.
  - Assert the lamp one-hot and mutual-exclusion invariants every cycle.
- Pedestrian cut: pulse ped_req for 1 cycle while NS_GREEN shows 0/8. Next tick loads 0/2. Following ticks give 0/1, then NS_YELLOW. ped_pend is 0 after the cut.
- Late request: pulse ped_req in EW_GREEN at count 0/2. Required: no cut, 0/1 then EW_YELLOW. ped_pend is cleared on EW_YELLOW entry. The next NS_GREEN runs the full 12 ticks.
- Mid-phase reset: assert rst asynchronously in EW_YELLOW between clock edges. Outputs go to reset values before the next edge, and the prescaler restarts at 0.
